// File: rtl/apb_pkg.sv
// Shared definitions for the APB master front-end: bus width defaults and FSM states.
package apb_pkg;

    localparam int PADDR_WIDTH = 12;
    localparam int PDATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the grant history register lives in the parent.
module rr_arbiter2
    import apb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_idx,
    output logic       gnt_any
);

    assign gnt_any = |req;
    // A lone requester always wins; on contention the one not served last time wins.
    assign gnt_idx = (&req) ? ~last_gnt : req[1];

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by the host CSR path (0) and the layer-config sequencer (1).
// Round-robin arbitration, SETUP/ACCESS sequencing and a bounded ACCESS phase.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int PADDR_WIDTH = apb_pkg::PADDR_WIDTH,
    parameter int PDATA_WIDTH = apb_pkg::PDATA_WIDTH,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     P_clk,
    input  logic                     P_rstn,
    input  logic [1:0]               rq_valid,
    input  logic [1:0]               rq_write,
    input  logic [2*PADDR_WIDTH-1:0] rq_addr,
    input  logic [2*PDATA_WIDTH-1:0] rq_wdata,
    output logic [1:0]               rq_ready,
    output logic [1:0]               rsp_valid,
    output logic [PDATA_WIDTH-1:0]   rsp_rdata,
    output logic                     rsp_err,
    output logic                     tmo_pulse,
    output logic [PADDR_WIDTH-1:0]   P_addr,
    output logic                     P_selx,
    output logic                     P_enable,
    output logic                     P_write,
    output logic [PDATA_WIDTH-1:0]   P_wdata,
    input  logic                     P_ready,
    input  logic                     P_slverr,
    input  logic [PDATA_WIDTH-1:0]   P_rdata
);

    localparam int SCNT_W = $clog2(SETUP_CYC + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

    apb_state_t              r_state;
    apb_state_t              w_next;
    logic [SCNT_W-1:0]       r_setup_cnt;
    logic [TCNT_W-1:0]       r_tmo_cnt;
    logic                    r_last_gnt;
    logic                    r_owner;
    logic [1:0]              r_rq_ready;
    logic [1:0]              r_rsp_valid;
    logic [PDATA_WIDTH-1:0]  r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_tmo_pulse;
    logic [PADDR_WIDTH-1:0]  r_addr;
    logic [PDATA_WIDTH-1:0]  r_wdata;
    logic                    r_write;
    logic                    r_psel;
    logic                    r_penable;
    logic                    w_gnt_idx;
    logic                    w_gnt_any;
    logic                    w_setup_done;
    logic                    w_ready_ok;
    logic                    w_tmo_hit;

    rr_arbiter2 u_arb (
        .req      (rq_valid),
        .last_gnt (r_last_gnt),
        .gnt_idx  (w_gnt_idx),
        .gnt_any  (w_gnt_any)
    );

    assign w_setup_done = (r_setup_cnt == SCNT_W'(SETUP_CYC - 1));
    // The first ACCESS cycle (count 0) never completes the transfer.
    assign w_ready_ok   = (r_tmo_cnt != '0) && P_ready;
    assign w_tmo_hit    = (r_tmo_cnt == TCNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any) w_next = SETUP;
            SETUP:   if (w_setup_done) w_next = ACCESS;
            ACCESS:  if (w_ready_ok || w_tmo_hit) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge P_clk) begin
        if (!P_rstn) begin
            r_state     <= IDLE;
            r_setup_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_last_gnt  <= 1'b1;
            r_owner     <= 1'b0;
            r_rq_ready  <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_tmo_pulse <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_setup_cnt <= '0;
                r_tmo_cnt   <= '0;
            end else begin
                if (r_state == SETUP)  r_setup_cnt <= r_setup_cnt + SCNT_W'(1);
                if (r_state == ACCESS) r_tmo_cnt   <= r_tmo_cnt + TCNT_W'(1);
            end

            r_rq_ready  <= '0;
            r_rsp_valid <= '0;
            r_tmo_pulse <= 1'b0;
            // Bus controls follow the next state so they line up with the phase.
            r_psel      <= (w_next == SETUP) || (w_next == ACCESS);
            r_penable   <= (w_next == ACCESS);

            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_owner               <= w_gnt_idx;
                        r_last_gnt            <= w_gnt_idx;
                        r_rq_ready[w_gnt_idx] <= 1'b1;
                        r_write               <= rq_write[w_gnt_idx];
                        r_addr  <= w_gnt_idx ? rq_addr[PADDR_WIDTH +: PADDR_WIDTH]
                                             : rq_addr[0 +: PADDR_WIDTH];
                        r_wdata <= w_gnt_idx ? rq_wdata[PDATA_WIDTH +: PDATA_WIDTH]
                                             : rq_wdata[0 +: PDATA_WIDTH];
                    end
                end
                ACCESS: begin
                    if (w_ready_ok) begin
                        r_rsp_rdata <= r_write ? '0 : P_rdata;
                        r_rsp_err   <= P_slverr;
                    end else if (w_tmo_hit) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_tmo_pulse <= 1'b1;
                    end
                end
                RESP: r_rsp_valid[r_owner] <= 1'b1;
                default: ;
            endcase
        end
    end

    assign rq_ready  = r_rq_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign tmo_pulse = r_tmo_pulse;
    assign P_addr    = r_addr;
    assign P_selx    = r_psel;
    assign P_enable  = r_penable;
    assign P_write   = r_write;
    assign P_wdata   = r_wdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized checks of apb_master_arbiter against a transaction-level model.
module tb_apb_master_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int SETUP = 2;
    localparam int TMO   = 16;

    logic              P_clk = 1'b0;
    logic              P_rstn;
    logic [1:0]        rq_valid;
    logic [1:0]        rq_write;
    logic [2*AW-1:0]   rq_addr;
    logic [2*DW-1:0]   rq_wdata;
    logic [1:0]        rq_ready;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              tmo_pulse;
    logic [AW-1:0]     P_addr;
    logic              P_selx;
    logic              P_enable;
    logic              P_write;
    logic [DW-1:0]     P_wdata;
    logic              P_ready;
    logic              P_slverr;
    logic [DW-1:0]     P_rdata;

    int checks   = 0;
    int failures = 0;
    int m_last   = 1;   // model of the round-robin history

    apb_master_arbiter #(
        .PADDR_WIDTH (AW),
        .PDATA_WIDTH (DW),
        .SETUP_CYC   (SETUP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .P_clk     (P_clk),
        .P_rstn    (P_rstn),
        .rq_valid  (rq_valid),
        .rq_write  (rq_write),
        .rq_addr   (rq_addr),
        .rq_wdata  (rq_wdata),
        .rq_ready  (rq_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tmo_pulse (tmo_pulse),
        .P_addr    (P_addr),
        .P_selx    (P_selx),
        .P_enable  (P_enable),
        .P_write   (P_write),
        .P_wdata   (P_wdata),
        .P_ready   (P_ready),
        .P_slverr  (P_slverr),
        .P_rdata   (P_rdata)
    );

    always #5 P_clk = ~P_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rq_ready"},  rq_ready,  0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"},   rsp_err,   0);
        chk({tag, "_tmo"},       tmo_pulse, 0);
        chk({tag, "_addr"},      P_addr,    0);
        chk({tag, "_selx"},      P_selx,    0);
        chk({tag, "_enable"},    P_enable,  0);
        chk({tag, "_write"},     P_write,   0);
        chk({tag, "_wdata"},     P_wdata,   0);
    endtask

    task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_valid[i]          = 1'b1;
        rq_write[i]          = wr;
        rq_addr[i*AW +: AW]  = a;
        rq_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge P_clk);
            if (rq_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // One complete transfer: target ready from ACCESS cycle wait_c onward.
    task automatic xfer(input logic keep, input int wait_c, input logic serr, input logic [DW-1:0] rd);
        int          w;
        int          done_k;
        int          last_idx;
        bit          tmo;
        bit          got;
        bit          in_setup;
        bit          in_acc;
        logic [1:0]  oh;
        logic        exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;

        if (rq_valid == 2'b11) w = (m_last == 1) ? 0 : 1;
        else                   w = rq_valid[1] ? 1 : 0;
        oh       = (w == 1) ? 2'b10 : 2'b01;
        exp_wr   = rq_write[w];
        exp_addr = rq_addr[w*AW +: AW];
        exp_wd   = rq_wdata[w*DW +: DW];
        done_k   = (wait_c < 1) ? 1 : wait_c;
        tmo      = (done_k > TMO - 1);
        if (tmo) done_k = TMO - 1;
        last_idx = SETUP + done_k + 2;
        exp_rd   = (tmo || exp_wr) ? '0 : rd;

        wait_accept(got);
        chk("accept_seen", {31'd0, got}, 1);
        if (!got) return;
        m_last = w;
        if (!keep) rq_valid[w] = 1'b0;

        for (int idx = 0; idx <= last_idx; idx++) begin
            if (idx > 0) @(negedge P_clk);
            in_setup = (idx < SETUP);
            in_acc   = (idx >= SETUP) && (idx <= SETUP + done_k);
            chk("rq_ready", rq_ready, (idx == 0) ? oh : 2'b00);
            chk("p_selx",   P_selx,   in_setup || in_acc);
            chk("p_enable", P_enable, in_acc);
            if (in_setup || in_acc) begin
                chk("p_addr",  P_addr,  exp_addr);
                chk("p_write", P_write, exp_wr);
                chk("p_wdata", P_wdata, exp_wd);
            end
            chk("tmo_pulse", tmo_pulse, (idx == SETUP + done_k + 1) && tmo);
            chk("rsp_valid", rsp_valid, (idx == last_idx) ? oh : 2'b00);
            if (idx == last_idx) begin
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_err",   rsp_err,   tmo || serr);
            end
            if (in_acc && (idx - SETUP) >= wait_c) begin
                P_ready  = 1'b1;
                P_rdata  = rd;
                P_slverr = serr;
            end else begin
                P_ready  = 1'b0;
                P_rdata  = $urandom;
                P_slverr = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        bit got;
        int sel;
        int wt;

        P_rstn   = 1'b0;
        rq_valid = '0;
        rq_write = '0;
        rq_addr  = '0;
        rq_wdata = '0;
        P_ready  = 1'b0;
        P_slverr = 1'b0;
        P_rdata  = '0;
        repeat (3) @(negedge P_clk);
        chk_all_zero("reset");
        P_rstn = 1'b1;
        @(negedge P_clk);

        // Single write from requester 0, ready in the second ACCESS cycle.
        post(0, 1'b1, 12'h400, 32'hA5A5_0001);
        xfer(1'b0, 1, 1'b0, 32'h0);

        // Read from requester 1.
        post(1, 1'b0, 12'h410, 32'h0);
        xfer(1'b0, 1, 1'b0, 32'h0000_1234);

        // Both requesters held valid: strict alternation.
        post(0, 1'b1, 12'h020, 32'h1111_0000);
        post(1, 1'b0, 12'h024, 32'h2222_0000);
        for (int n = 0; n < 4; n++) xfer(1'b1, 1 + n, 1'b0, 32'h3000_0000 + n);
        rq_valid = 2'b00;

        // Target never ready: timeout.
        post(0, 1'b0, 12'h420, 32'h0);
        xfer(1'b0, 100, 1'b0, 32'hFFFF_FFFF);
        chk("tmo_bus_idle", P_selx, 0);

        // Slave error with ready.
        post(1, 1'b0, 12'h3F0, 32'h0);
        xfer(1'b0, 2, 1'b1, 32'hCAFE_0000);

        // Ready asserted in the very first ACCESS cycle must be ignored.
        post(0, 1'b0, 12'h0F0, 32'h0);
        xfer(1'b0, 0, 1'b0, 32'h0BAD_F00D);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++)
                if (!rq_valid[i] && $urandom_range(0, 2) != 0)
                    post(i, 1'($urandom_range(0, 1)), 12'($urandom), $urandom);
            if (rq_valid == 2'b00)
                post(0, 1'($urandom_range(0, 1)), 12'($urandom), $urandom);
            sel = $urandom_range(0, 9);
            wt  = (sel < 7) ? $urandom_range(0, 4) : ((sel == 7) ? 15 : ((sel == 8) ? 16 : 14));
            xfer(1'b0, wt, 1'($urandom_range(0, 1)), $urandom);
        end
        while (rq_valid != 2'b00) xfer(1'b0, 1, 1'b0, 32'h0);

        // Reset in the middle of ACCESS.
        post(0, 1'b1, 12'h100, 32'hDEAD_BEEF);
        wait_accept(got);
        chk("rst_accept", rq_ready, 2'b01);
        rq_valid = 2'b00;
        repeat (3) @(negedge P_clk);
        chk("rst_pre_enable", P_enable, 1);
        P_rstn = 1'b0;
        @(negedge P_clk);
        chk("rst_selx",      P_selx,    0);
        chk("rst_enable",    P_enable,  0);
        chk("rst_rsp_valid", rsp_valid, 0);
        P_rstn = 1'b1;
        m_last = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge P_clk);
            chk("rst_no_rsp", rsp_valid, 0);
            chk("rst_no_sel", P_selx,    0);
        end
        post(1, 1'b0, 12'h104, 32'h0);
        xfer(1'b0, 1, 1'b0, 32'h0000_0055);

        // Leave requester 0 as last winner, then reset while idle.
        post(0, 1'b0, 12'h108, 32'h0);
        xfer(1'b0, 3, 1'b0, 32'h0000_00AA);
        P_rstn = 1'b0;
        @(negedge P_clk);
        chk_all_zero("idle_reset");
        P_rstn = 1'b1;
        m_last = 1;
        post(0, 1'b1, 12'h200, 32'h0000_0A0A);
        post(1, 1'b1, 12'h204, 32'h0000_0B0B);
        xfer(1'b0, 1, 1'b0, 32'h0);
        xfer(1'b0, 1, 1'b0, 32'h0);

        repeat (4) @(negedge P_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
